i2c_byte_engine: RTL

Parametrised I2C master byte engine. Generalises the fixed per-bit data-state chain into one DATA state with a bit counter and four quarter-phases per bit, timed by a programmable divisor. Adds DATA_W-wide frames, repeated start, read/write, slave clock stretching and arbitration-loss detection. Sits between the command-level controller and the open-drain SCL/SDA pads.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_byte_engine_if.sv | 47 ++++
 rtl/i2c_phase_timer.sv | 59 +++++
 rtl/i2c_byte_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C master byte engine.
// States, quarter-phase codes and open-drain levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    k_idle,
    k_start,
    k_data,
    k_ack,
    k_hold,
    k_stop
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t Q0 = 2'd0;
  localparam phase_t Q1 = 2'd1;
  localparam phase_t Q2 = 2'd2;
  localparam phase_t Q3 = 2'd3;

  localparam logic OE_PULL = 1'b1;
  localparam logic OE_REL  = 1'b0;

  // SCL is held low for the first half of a bit and released for the second
  function automatic logic bit_scl(phase_t p);
    return (p == Q0 || p == Q1) ? OE_PULL : OE_REL;
  endfunction

endpackage

// File: rtl/i2c_byte_engine_if.sv
// Command / response bundle between the controller and the byte engine.
// master = command issuer, slave = byte engine.
interface i2c_byte_engine_if #(
  parameter int DATA_W = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_start;
  logic              cmd_stop;
  logic              cmd_read;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ack_out;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_nack;
  logic              rsp_arb_lost;

  modport master (
    output cmd_valid,
    output cmd_start,
    output cmd_stop,
    output cmd_read,
    output cmd_data,
    output cmd_ack_out,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_nack,
    input  rsp_arb_lost
  );

  modport slave (
    input  cmd_valid,
    input  cmd_start,
    input  cmd_stop,
    input  cmd_read,
    input  cmd_data,
    input  cmd_ack_out,
    output cmd_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_nack,
    output rsp_arb_lost
  );

endinterface

// File: rtl/i2c_phase_timer.sv
// Quarter-phase timer: divisor latch, phase counter, stretch hold.
// Each phase lasts div+1 cycles unless the slave stretches SCL.
module i2c_phase_timer
  import i2c_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  input  logic             stretch_i,
  output phase_t           phase_o,
  output logic             done_o
);

  logic [DIV_W-1:0] ctr_q, ctr_d;
  logic [DIV_W-1:0] div_q, div_d;
  phase_t           phase_q, phase_d;
  logic             at_end;

  assign at_end  = (ctr_q == div_q);
  assign done_o  = run_i && !stretch_i && at_end;
  assign phase_o = phase_q;

  always_comb begin
    ctr_d   = ctr_q;
    div_d   = div_q;
    phase_d = phase_q;
    if (load_i) begin
      div_d   = div_i;
      ctr_d   = '0;
      phase_d = Q0;
    end else if (run_i) begin
      if (stretch_i) begin
        ctr_d = '0;
      end else if (at_end) begin
        ctr_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        ctr_d = ctr_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q   <= '0;
      div_q   <= '0;
      phase_q <= Q0;
    end else begin
      ctr_q   <= ctr_d;
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_byte_engine.sv
// I2C master byte engine: START, DATA_W bits, ACK, optional STOP.
// Drives open-drain enables; samples SDA mid-high of each bit.
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clock_divisor,
  i2c_byte_engine_if.slave bus,
  output logic             busy,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              read_q, read_d;
  logic              stop_q, stop_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              nsh_q, nsh_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rn_q, rn_d;
  logic              arb_q, arb_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;

  logic   ready, accept, done, stretch, run, arb_hit;
  phase_t phase, ph_n;

  assign ready  = (state_q == k_idle) || (state_q == k_hold);
  assign accept = bus.cmd_valid && ready;
  assign run    = !ready;
  assign stretch = ((state_q == k_data) || (state_q == k_ack))
                && (phase == Q2) && !scl_i;
  assign ph_n   = accept ? Q0 : (done ? phase + 2'd1 : phase);

  i2c_phase_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .div_i    (clock_divisor),
    .run_i    (run),
    .stretch_i(stretch),
    .phase_o  (phase),
    .done_o   (done)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    read_d  = read_q;
    stop_d  = stop_q;
    ack_d   = ack_q;
    sh_d    = sh_q;
    nsh_d   = nsh_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    rn_d    = rn_q;
    arb_d   = arb_q;
    arb_hit = 1'b0;
    if (accept) begin
      data_d  = bus.cmd_data;
      read_d  = bus.cmd_read;
      stop_d  = bus.cmd_stop;
      ack_d   = bus.cmd_ack_out;
      bit_d   = IW'(DATA_W - 1);
      sh_d    = '0;
      state_d = (state_q == k_idle || bus.cmd_start) ? k_start : k_data;
    end else if (done) begin
      unique case (state_q)
        k_start: begin
          if (phase == Q1 && !sda_i) arb_hit = 1'b1;
          if (phase == Q3) state_d = k_data;
        end
        k_data: begin
          if (phase == Q2) begin
            sh_d[bit_q] = sda_i;
            // released a 1 but someone else holds SDA low
            if (!read_q && data_q[bit_q] && !sda_i) arb_hit = 1'b1;
          end
          if (phase == Q3) begin
            if (bit_q == '0) state_d = k_ack;
            else             bit_d   = bit_q - IW'(1);
          end
        end
        k_ack: begin
          if (phase == Q2) nsh_d = sda_i;
          if (phase == Q3) begin
            rv_d    = 1'b1;
            rd_d    = sh_q;
            rn_d    = nsh_q;
            arb_d   = 1'b0;
            state_d = stop_q ? k_stop : k_hold;
          end
        end
        k_stop: begin
          if (phase == Q3) state_d = k_idle;
        end
        default: ;
      endcase
      if (arb_hit) begin
        rv_d    = 1'b1;
        rd_d    = sh_d;
        arb_d   = 1'b1;
        state_d = k_idle;
      end
    end
  end

  // line levels follow the state/phase that becomes current next cycle
  always_comb begin
    scl_d = OE_REL;
    sda_d = OE_REL;
    unique case (state_d)
      k_start: begin
        scl_d = (ph_n == Q0 || ph_n == Q3) ? OE_PULL : OE_REL;
        sda_d = (ph_n == Q2 || ph_n == Q3) ? OE_PULL : OE_REL;
      end
      k_data: begin
        scl_d = bit_scl(ph_n);
        sda_d = read_d ? OE_REL : !data_d[bit_d];
      end
      k_ack: begin
        scl_d = bit_scl(ph_n);
        sda_d = read_d ? !ack_d : OE_REL;
      end
      k_hold: begin
        scl_d = OE_PULL;
        sda_d = OE_REL;
      end
      k_stop: begin
        scl_d = (ph_n == Q0) ? OE_PULL : OE_REL;
        sda_d = (ph_n == Q0 || ph_n == Q1) ? OE_PULL : OE_REL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= k_idle;
      bit_q   <= '0;
      data_q  <= '0;
      read_q  <= 1'b0;
      stop_q  <= 1'b0;
      ack_q   <= 1'b0;
      sh_q    <= '0;
      nsh_q   <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rn_q    <= 1'b0;
      arb_q   <= 1'b0;
      scl_q   <= OE_REL;
      sda_q   <= OE_REL;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      read_q  <= read_d;
      stop_q  <= stop_d;
      ack_q   <= ack_d;
      sh_q    <= sh_d;
      nsh_q   <= nsh_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      arb_q   <= arb_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign bus.cmd_ready    = ready;
  assign bus.rsp_valid    = rv_q;
  assign bus.rsp_data     = rd_q;
  assign bus.rsp_nack     = rn_q;
  assign bus.rsp_arb_lost = arb_q;
  assign busy             = (state_q != k_idle);
  assign scl_oe           = scl_q;
  assign sda_oe           = sda_q;

endmodule
